// File: rtl/dtfag_exp_seq_pkg.sv
// Shared widths, FSM encoding and digit-slice offsets for the DTFAG exponent sequencer.
package dtfag_exp_seq_pkg;

    localparam int unsigned RADIX_W = 4;
    localparam int unsigned EXP_W   = 3 * RADIX_W;
    localparam int unsigned CNT_W   = EXP_W + 1;

    // Digit positions inside an exponent e = {t, i, j}
    localparam int unsigned J_OFF = 0;
    localparam int unsigned I_OFF = RADIX_W;
    localparam int unsigned T_OFF = 2 * RADIX_W;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_FIN_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_FIN  = ST_FIN_ENC
    } state_t;

    // Largest meaningful element count when the index is bit-reversed
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << EXP_W;

endpackage

// File: rtl/dtfag_exp_seq_if.sv
// Output stream from the exponent sequencer to the AGU / twiddle ROM.
interface dtfag_exp_seq_if;
    import dtfag_exp_seq_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [RADIX_W-1:0] DTFAG_t;
    logic [RADIX_W-1:0] DTFAG_i;
    logic [RADIX_W-1:0] DTFAG_j;
    logic               ROM_CEN;

    modport master (
        output out_valid, DTFAG_t, DTFAG_i, DTFAG_j, ROM_CEN,
        input  out_ready
    );

    modport slave (
        input  out_valid, DTFAG_t, DTFAG_i, DTFAG_j, ROM_CEN,
        output out_ready
    );

endinterface

// File: rtl/dtfag_exp_acc.sv
// Exponent accumulator: load base, step by stride, else hold.
// DTFAG_SEQ_BITREV_EN selects a bit-reversed element index (multiply-free).
module dtfag_exp_acc
    import dtfag_exp_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [EXP_W-1:0] base,
    input  logic [EXP_W-1:0] stride,
    output logic [EXP_W-1:0] exp_q
);

    logic [EXP_W-1:0] stride_q;
    logic [EXP_W-1:0] delta_c;

`ifdef DTFAG_SEQ_BITREV_EN
    logic [EXP_W-1:0] rev_q;
    logic [EXP_W-1:0] rev_next_c;
    logic             found_c;

    // Reverse-increment of the index: flip ones from the MSB down through the first zero at
    // position p. The exponent then moves by 2^p - (2^EXP_W - 2^(p+1)) = 3*stride << p (mod 2^EXP_W).
    always_comb begin
        rev_next_c = rev_q;
        delta_c    = '0;
        found_c    = 1'b0;
        for (int b = EXP_W - 1; b >= 0; b--) begin
            if (!found_c) begin
                rev_next_c[b] = ~rev_q[b];
                if (!rev_q[b]) begin
                    found_c = 1'b1;
                    delta_c = EXP_W'((stride_q + (stride_q << 1)) << b);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= '0;
        end else if (load) begin
            rev_q <= '0;
        end else if (step) begin
            rev_q <= rev_next_c;
        end
    end
`else
    always_comb delta_c = stride_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q    <= '0;
            stride_q <= '0;
        end else if (load) begin
            exp_q    <= base;
            stride_q <= stride;
        end else if (step) begin
            exp_q    <= exp_q + delta_c;
        end
    end

endmodule

// File: rtl/dtfag_exp_seq.sv
// DTFAG twiddle-exponent sequencer: issues base + k*stride over a valid/ready stream.
// Optional bit-reversed index order under DTFAG_SEQ_BITREV_EN.
module dtfag_exp_seq
    import dtfag_exp_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [EXP_W-1:0]      cfg_base,
    input  logic [EXP_W-1:0]      cfg_stride,
    input  logic [CNT_W-1:0]      cfg_count,
    dtfag_exp_seq_if.master       bus,
    output logic                  busy,
    output logic                  done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_clip_c;
    logic             out_valid_q, busy_q, done_q;
    logic             handshake_c, last_c, load_c, step_c;
    logic [EXP_W-1:0] exp_q;

    always_comb handshake_c = out_valid_q & bus.out_ready;
    always_comb last_c      = (k_q == count_q - CNT_W'(1));

`ifdef DTFAG_SEQ_BITREV_EN
    always_comb count_clip_c = (cfg_count > MAX_COUNT) ? MAX_COUNT : cfg_count;
`else
    always_comb count_clip_c = cfg_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            count_q     <= count_d;
            out_valid_q <= (state_d == ST_RUN);
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_FIN);
        end
    end

    // Next state plus accumulator control; start only honoured in IDLE
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        count_d = count_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_count != '0) begin
                        load_c  = 1'b1;
                        count_d = count_clip_c;
                        k_d     = '0;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (handshake_c) begin
                    if (last_c) begin
                        state_d = ST_FIN;
                    end else begin
                        step_c = 1'b1;
                        k_d    = k_q + CNT_W'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    dtfag_exp_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .step   (step_c),
        .base   (cfg_base),
        .stride (cfg_stride),
        .exp_q  (exp_q)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.DTFAG_t   = exp_q[T_OFF +: RADIX_W];
    assign bus.DTFAG_i   = exp_q[I_OFF +: RADIX_W];
    assign bus.DTFAG_j   = exp_q[J_OFF +: RADIX_W];
    assign bus.ROM_CEN   = ~handshake_c;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_dtfag_exp_seq.sv
// Self-checking bench for dtfag_exp_seq: queue-based reference model plus directed literal checks.
module tb_dtfag_exp_seq;
    import dtfag_exp_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [EXP_W-1:0] cfg_base;
    logic [EXP_W-1:0] cfg_stride;
    logic [CNT_W-1:0] cfg_count;
    logic             busy;
    logic             done;

    dtfag_exp_seq_if bus ();

    dtfag_exp_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_base   (cfg_base),
        .cfg_stride (cfg_stride),
        .cfg_count  (cfg_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] digits();
        return {bus.DTFAG_t, bus.DTFAG_i, bus.DTFAG_j};
    endfunction

    // Element k of a sequence straight from the definition e_k = base + idx(k)*stride mod 2^EXP_W
    function automatic logic [EXP_W-1:0] elem(input logic [EXP_W-1:0] b,
                                              input logic [EXP_W-1:0] s, input int k);
        logic [EXP_W-1:0] kk;
        logic [EXP_W-1:0] idx;
        kk  = EXP_W'(k);
        idx = kk;
`ifdef DTFAG_SEQ_BITREV_EN
        for (int n = 0; n < int'(EXP_W); n++) idx[n] = kk[int'(EXP_W) - 1 - n];
`endif
        return EXP_W'(b + idx * s);
    endfunction

    // Reference model: queue of exponents still to be accepted, last accepted value, done flag
    logic [EXP_W-1:0] m_q[$];
    logic [EXP_W-1:0] m_hold;
    bit               m_done;

    always @(posedge clk) begin
        int n;
        if (rst) begin
            m_q.delete();
            m_hold = '0;
            m_done = 1'b0;
        end else if (m_q.size() != 0) begin
            m_done = 1'b0;
            if (bus.out_ready) begin
                m_hold = m_q.pop_front();
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            if (cfg_count == '0) begin
                m_done = 1'b1;
            end else begin
                n = int'(cfg_count);
`ifdef DTFAG_SEQ_BITREV_EN
                if (n > (1 << EXP_W)) n = 1 << EXP_W;
`endif
                for (int k = 0; k < n; k++) m_q.push_back(elem(cfg_base, cfg_stride, k));
            end
        end
    end

    // Compare every cycle at the falling edge
    always @(negedge clk) begin
        if (check_en) begin
            logic vld;
            logic [EXP_W-1:0] e;
            vld = (m_q.size() != 0);
            e   = vld ? m_q[0] : m_hold;
            chk("valid", 32'(bus.out_valid), 32'(vld));
            chk("exp",   32'(digits()),      32'(e));
            chk("cen",   32'(bus.ROM_CEN),   32'(!(vld && bus.out_ready)));
            chk("busy",  32'(busy),          32'(vld));
            chk("done",  32'(done),          32'(m_done));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [EXP_W-1:0] b, input logic [EXP_W-1:0] s,
                      input logic [CNT_W-1:0] c);
        cfg_base   = b;
        cfg_stride = s;
        cfg_count  = c;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        int hs;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_base      = '0;
        cfg_stride    = '0;
        cfg_count     = '0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        check_en = 1'b1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_cen",   32'(bus.ROM_CEN),   32'd1);
        chk("rst_exp",   32'(digits()),      32'd0);
        rst = 1'b0;
        cyc();

        // Linear run
        bus.out_ready = 1'b1;
        go(12'h000, 12'h001, 13'd5);
        for (int i = 0; i < 5; i++) begin
            chk("lin_exp",  32'(digits()),    32'(i));
            chk("lin_cen",  32'(bus.ROM_CEN), 32'd0);
            chk("lin_busy", 32'(busy),        32'd1);
            cyc();
        end
        chk("lin_done", 32'(done), 32'd1);
        chk("lin_busy_off", 32'(busy), 32'd0);
        cyc();
        chk("lin_done_pulse", 32'(done), 32'd0);

        // Stride with wrap-around
        go(12'hFF0, 12'h010, 13'd3);
        chk("wrap_e0", 32'(digits()), 32'h0FF0);
        cyc();
        chk("wrap_e1", 32'(digits()), 32'h0000);
        cyc();
        chk("wrap_e2", 32'(digits()), 32'h0010);
        cyc();
        chk("wrap_done", 32'(done), 32'd1);
        cyc();

        // Back-pressure
        pat = 7'b1011001;
        hs  = 0;
        go(12'h123, 12'h001, 13'd4);
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i];
            #1;
            if (bus.out_valid && bus.out_ready) hs++;
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_handshakes", 32'(hs), 32'd4);
        chk("bp_done", 32'(done), 32'd1);
        cyc();

        // Zero count
        go(12'h123, 12'h001, 13'd0);
        chk("zero_done",  32'(done),          32'd1);
        chk("zero_busy",  32'(busy),          32'd0);
        chk("zero_valid", 32'(bus.out_valid), 32'd0);
        cyc();

        // Reset mid-run, then a fresh single-element sequence
        go(12'h200, 12'h003, 13'd8);
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_busy",  32'(busy),          32'd0);
        chk("mrst_cen",   32'(bus.ROM_CEN),   32'd1);
        chk("mrst_exp",   32'(digits()),      32'd0);
        rst = 1'b0;
        go(12'h005, 12'h000, 13'd1);
        chk("mrst_j", 32'(bus.DTFAG_j), 32'd5);
        cyc();
        cyc();

        // Start while busy is ignored
        go(12'h100, 12'h002, 13'd3);
        cyc();
        cfg_base  = 12'hABC;
        cfg_count = 13'd7;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        chk("sb_e2", 32'(digits()), 32'h0104);
        cyc();
        chk("sb_done", 32'(done), 32'd1);
        cyc();

        // Randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 299) == 0);
            start         = ($urandom_range(0, 4) == 0);
            cfg_base      = EXP_W'($urandom);
            cfg_stride    = EXP_W'($urandom);
            cfg_count     = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 60))
                                                         : CNT_W'($urandom_range(0, 9));
            cyc();
        end
        rst   = 1'b0;
        start = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
